// File: rtl/xadc_drp_arbiter_if.sv
// Bundle of both requester ports and the XADC DRP pins around xadc_drp_arbiter.
// slave = arbiter side, master = requesters plus XADC primitive side.
interface xadc_drp_arbiter_if #(
    parameter int DRP_ADDRESS_BITS = 7,
    parameter int DRP_DATA_BITS    = 16
);
    logic                        request0;
    logic                        request1;
    logic                        writeEnable0;
    logic                        writeEnable1;
    logic [DRP_ADDRESS_BITS-1:0] address0;
    logic [DRP_ADDRESS_BITS-1:0] address1;
    logic [DRP_DATA_BITS-1:0]    writeData0;
    logic [DRP_DATA_BITS-1:0]    writeData1;
    logic                        done0;
    logic                        done1;
    logic [DRP_DATA_BITS-1:0]    readData0;
    logic [DRP_DATA_BITS-1:0]    readData1;
    logic                        error0;
    logic                        error1;

    logic                        DRPEnable;
    logic                        DRPWriteEnable;
    logic [DRP_ADDRESS_BITS-1:0] DRPAddress;
    logic [DRP_DATA_BITS-1:0]    DRPDataIn;
    logic                        DRPReady;
    logic [DRP_DATA_BITS-1:0]    DRPDataOut;

    modport slave (
        input  request0, request1, writeEnable0, writeEnable1,
        input  address0, address1, writeData0, writeData1,
        output done0, done1, readData0, readData1, error0, error1,
        output DRPEnable, DRPWriteEnable, DRPAddress, DRPDataIn,
        input  DRPReady, DRPDataOut
    );

    modport master (
        output request0, request1, writeEnable0, writeEnable1,
        output address0, address1, writeData0, writeData1,
        input  done0, done1, readData0, readData1, error0, error1,
        input  DRPEnable, DRPWriteEnable, DRPAddress, DRPDataIn,
        output DRPReady, DRPDataOut
    );
endinterface

// File: rtl/xadc_drp_arbiter.sv
// Shares one XADC DRP between the sample reader (port 0) and the config path (port 1).
// Optional DRP watchdog is built when DRP_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no transaction in flight; arbitrate (skipped in a done cycle)
// ST_WAIT | DEN issued, waiting for DRDY (or watchdog expiry)
module xadc_drp_arbiter #(
    parameter int DRP_ADDRESS_BITS = 7,
    parameter int DRP_DATA_BITS    = 16,
    parameter int MAX_BURST        = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic              clock,
    input  logic              resetN,
    xadc_drp_arbiter_if.slave drp,
    output logic              busy
);

    localparam int BURST_BITS = $clog2(MAX_BURST + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic                        grant0;
    logic                        grant1;
    logic                        complete;
    logic                        timed_out;
    logic                        expired;
    logic                        owner;
    logic                        burst_limit;
    logic [BURST_BITS-1:0]       burst_count;
    logic                        den_q;
    logic                        dwe_q;
    logic [DRP_ADDRESS_BITS-1:0] addr_q;
    logic [DRP_DATA_BITS-1:0]    din_q;
    logic                        done0_q;
    logic                        done1_q;
    logic [DRP_DATA_BITS-1:0]    rdata0_q;
    logic [DRP_DATA_BITS-1:0]    rdata1_q;

    assign burst_limit = (burst_count == BURST_BITS'(MAX_BURST));

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                // A requester still holds its request during its done cycle.
                if (!done0_q && !done1_q) begin
                    if (drp.request1 && (!drp.request0 || burst_limit)) begin
                        grant1 = 1'b1;
                    end else if (drp.request0) begin
                        grant0 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (drp.DRPReady) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end else if (expired) begin
                    timed_out  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            burst_count <= '0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state   <= state_next;
            den_q   <= grant0 | grant1;
            dwe_q   <= grant1 ? drp.writeEnable1 : (grant0 & drp.writeEnable0);
            done0_q <= (complete | timed_out) & ~owner;
            done1_q <= (complete | timed_out) & owner;

            if (grant1) begin
                owner  <= 1'b1;
                addr_q <= drp.address1;
                din_q  <= drp.writeData1;
            end else if (grant0) begin
                owner  <= 1'b0;
                addr_q <= drp.address0;
                din_q  <= drp.writeData0;
            end

            if (complete) begin
                if (owner) rdata1_q <= drp.DRPDataOut;
                else       rdata0_q <= drp.DRPDataOut;
            end else if (timed_out) begin
                if (owner) rdata1_q <= '0;
                else       rdata0_q <= '0;
            end

            // The burst guard only matters while port 1 is actually waiting.
            if (!drp.request1 || grant1) begin
                burst_count <= '0;
            end else if (grant0 && !burst_limit) begin
                burst_count <= burst_count + BURST_BITS'(1);
            end
        end
    end

`ifdef DRP_TIMEOUT_EN
    localparam int TIMER_BITS = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_BITS-1:0] timer;
    logic                  error0_q;
    logic                  error1_q;

    // Down-counter loaded on grant; terminal count in WAIT means no DRDY arrived.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            timer    <= '0;
            error0_q <= 1'b0;
            error1_q <= 1'b0;
        end else begin
            if (grant0 || grant1) begin
                timer <= TIMER_BITS'(TIMEOUT_CYCLES - 1);
            end else if (state == ST_WAIT && timer != '0) begin
                timer <= timer - TIMER_BITS'(1);
            end
            error0_q <= timed_out & ~owner;
            error1_q <= timed_out & owner;
        end
    end

    assign expired    = (state == ST_WAIT) && (timer == '0);
    assign drp.error0 = error0_q;
    assign drp.error1 = error1_q;
`else
    assign expired    = 1'b0;
    assign drp.error0 = 1'b0;
    assign drp.error1 = 1'b0;
`endif

    assign drp.DRPEnable      = den_q;
    assign drp.DRPWriteEnable = dwe_q;
    assign drp.DRPAddress     = addr_q;
    assign drp.DRPDataIn      = din_q;
    assign drp.done0          = done0_q;
    assign drp.done1          = done1_q;
    assign drp.readData0      = rdata0_q;
    assign drp.readData1      = rdata1_q;
    assign busy               = (state == ST_WAIT);

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Scoreboard bench for xadc_drp_arbiter: requester agents, a simple XADC DRP model,
// and a monitor that pops expected DEN/done events in service order.
module tb_xadc_drp_arbiter;

    localparam int AW = 7;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clock  = 1'b0;
    logic resetN = 1'b0;
    logic busy;

    always #5 clock = ~clock;

    xadc_drp_arbiter_if #(.DRP_ADDRESS_BITS(AW), .DRP_DATA_BITS(DW)) bus ();

    xadc_drp_arbiter #(
        .DRP_ADDRESS_BITS(AW),
        .DRP_DATA_BITS   (DW),
        .MAX_BURST       (4),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .drp   (bus.slave),
        .busy  (busy)
    );

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] di;
        logic [DW-1:0] rdata;
        logic          err;
    } txn_t;

    txn_t          den_q[$];
    txn_t          done_q[$];
    logic [DW-1:0] xadc_mem [0:127];
    logic [DW-1:0] exp_mem  [0:127];

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   den_cyc[2];
    int   done_cyc[2];
    logic drdy_edge   = 1'b0;
    logic den_prev    = 1'b0;
    logic done_prev   = 1'b0;
    int   drdy_delay  = 1;
    bit   xadc_mute   = 1'b0;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 32'h13) return 16'h0ABC;
        return 16'(32'h5A00 + a * 37);
    endfunction

    // ---------------- XADC DRP model ----------------
    logic [DW-1:0] resp_data;
    bit            resp_pending = 1'b0;
    int            resp_cnt     = 0;

    initial begin
        bus.DRPReady   = 1'b0;
        bus.DRPDataOut = 16'hDEAD;
        forever begin
            @(negedge clock);
            if (bus.DRPEnable === 1'b1 && !xadc_mute) begin
                resp_data = bus.DRPWriteEnable ? bus.DRPDataIn : xadc_mem[bus.DRPAddress];
                if (bus.DRPWriteEnable) xadc_mem[bus.DRPAddress] = bus.DRPDataIn;
                if (drdy_delay == 0) begin
                    bus.DRPReady   = 1'b1;
                    bus.DRPDataOut = resp_data;
                end else begin
                    resp_pending = 1'b1;
                    resp_cnt     = drdy_delay;
                end
            end
            @(posedge clock);
            #1;
            bus.DRPReady   = 1'b0;
            bus.DRPDataOut = 16'hDEAD;
            if (resp_pending) begin
                if (resp_cnt <= 1) begin
                    bus.DRPReady   = 1'b1;
                    bus.DRPDataOut = resp_data;
                    resp_pending   = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clock) begin
        cyc       <= cyc + 1;
        drdy_edge <= bus.DRPReady;
    end

    txn_t          mt;
    int            m_port;
    logic [DW-1:0] m_data;
    logic          m_err;

    always @(negedge clock) begin
        if (bus.DRPEnable === 1'b1) begin
            vectors++;
            if (den_q.size() == 0) begin
                miscompares++;
                $display("FAIL den_unexpected: DEN addr=%h we=%b, required no DEN", bus.DRPAddress, bus.DRPWriteEnable);
            end else begin
                mt = den_q.pop_front();
                den_cyc[mt.port] = cyc;
                if (den_prev !== 1'b0 || bus.DRPAddress !== mt.addr || bus.DRPWriteEnable !== mt.we
                    || bus.DRPDataIn !== mt.di) begin
                    miscompares++;
                    $display("FAIL den_fields: prev=%b addr=%h we=%b di=%h, required prev=0 addr=%h we=%b di=%h",
                             den_prev, bus.DRPAddress, bus.DRPWriteEnable, bus.DRPDataIn, mt.addr, mt.we, mt.di);
                end
            end
        end
        if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
            vectors++;
            m_port = (bus.done1 === 1'b1) ? 1 : 0;
            m_data = m_port ? bus.readData1 : bus.readData0;
            m_err  = m_port ? bus.error1 : bus.error0;
            if (done_q.size() == 0) begin
                miscompares++;
                $display("FAIL done_unexpected: done on port %0d, required no done", m_port);
            end else begin
                mt = done_q.pop_front();
                done_cyc[mt.port] = cyc;
                if ((bus.done0 === 1'b1 && bus.done1 === 1'b1) || done_prev !== 1'b0 || m_port != mt.port
                    || m_data !== mt.rdata || m_err !== mt.err || drdy_edge !== ~mt.err) begin
                    miscompares++;
                    $display("FAIL done_fields: port=%0d data=%h err=%b prev=%b drdy_before=%b, required port=%0d data=%h err=%b prev=0 drdy_before=%b",
                             m_port, m_data, m_err, done_prev, drdy_edge, mt.port, mt.rdata, mt.err, ~mt.err);
                end
            end
        end
        den_prev  = bus.DRPEnable;
        done_prev = bus.done0 | bus.done1;
    end

    // ---------------- helpers ----------------
    task automatic push_txn(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic err, input bit completes);
        txn_t t;
        t.port = p;
        t.we   = we;
        t.addr = a;
        t.di   = d;
        t.err  = err;
        if (err)     t.rdata = '0;
        else if (we) t.rdata = d;
        else         t.rdata = exp_mem[a];
        if (we && !err) exp_mem[a] = d;
        den_q.push_back(t);
        if (completes) done_q.push_back(t);
    endtask

    task automatic req_start(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.writeEnable0 = we;
            bus.address0     = a;
            bus.writeData0   = d;
            bus.request0     = 1'b1;
        end else begin
            bus.writeEnable1 = we;
            bus.address1     = a;
            bus.writeData1   = d;
            bus.request1     = 1'b1;
        end
    endtask

    task automatic req_wait_done(input int p, input int budget);
        int n    = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            seen = (p == 0) ? (bus.done0 === 1'b1) : (bus.done1 === 1'b1);
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done%0d_wait: no done after %0d cycles, required within %0d", p, n, budget);
        end
        @(posedge clock);
        #1;
        if (p == 0) bus.request0 = 1'b0;
        else        bus.request1 = 1'b0;
    endtask

    task automatic wait_den(input int budget, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            seen = (bus.DRPEnable === 1'b1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.done0, bus.done1, bus.error0, bus.error1, bus.DRPEnable, bus.DRPWriteEnable, busy} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {bus.done0, bus.done1, bus.error0, bus.error1, bus.DRPEnable, bus.DRPWriteEnable, busy});
        end
        vectors++;
        if (bus.readData0 !== '0 || bus.readData1 !== '0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h/%h, required 0000/0000", bus.readData0, bus.readData1);
        end
        vectors++;
        if (bus.DRPAddress !== '0 || bus.DRPDataIn !== '0) begin
            miscompares++;
            $display("FAIL reset_drp_bus: addr=%h di=%h, required 00/0000", bus.DRPAddress, bus.DRPDataIn);
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        repeat (2) @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || bus.DRPEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy=%b den=%b, required 0/0", busy, bus.DRPEnable);
        end
    endtask

    task automatic test_port0_read();
        int start_cyc;
        bit seen;
        drdy_delay = 3;
        push_txn(0, 1'b0, 7'h13, 16'h1111, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        start_cyc = cyc;
        req_start(0, 1'b0, 7'h13, 16'h1111);
        wait_den(10, seen);
        vectors++;
        if (!seen || bus.DRPWriteEnable !== 1'b0 || bus.DRPAddress !== 7'h13 || busy !== 1'b1 || cyc != start_cyc + 1) begin
            miscompares++;
            $display("FAIL p0_read_den: seen=%b dwe=%b addr=%h busy=%b at=%0d, required 1/0/13/1 at %0d",
                     seen, bus.DRPWriteEnable, bus.DRPAddress, busy, cyc, start_cyc + 1);
        end
        req_wait_done(0, 20);
        vectors++;
        if (done_cyc[0] - den_cyc[0] != 4 || bus.readData0 !== 16'h0ABC || busy !== 1'b0
            || bus.DRPAddress !== 7'h13 || bus.readData1 !== '0) begin
            miscompares++;
            $display("FAIL p0_read_result: latency=%0d rdata0=%h busy=%b addr=%h rdata1=%h, required 4/0abc/0/13/0000",
                     done_cyc[0] - den_cyc[0], bus.readData0, busy, bus.DRPAddress, bus.readData1);
        end
    endtask

    task automatic test_port1_write();
        bit seen;
        drdy_delay = 2;
        push_txn(1, 1'b1, 7'h41, 16'h2F00, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        req_start(1, 1'b1, 7'h41, 16'h2F00);
        wait_den(10, seen);
        vectors++;
        if (!seen || bus.DRPWriteEnable !== 1'b1 || bus.DRPDataIn !== 16'h2F00 || bus.DRPAddress !== 7'h41) begin
            miscompares++;
            $display("FAIL p1_write_den: seen=%b dwe=%b di=%h addr=%h, required 1/1/2f00/41",
                     seen, bus.DRPWriteEnable, bus.DRPDataIn, bus.DRPAddress);
        end
        @(negedge clock);
        vectors++;
        if (bus.DRPEnable !== 1'b0 || bus.DRPWriteEnable !== 1'b0) begin
            miscompares++;
            $display("FAIL p1_write_pulse: den=%b dwe=%b one cycle later, required 0/0", bus.DRPEnable, bus.DRPWriteEnable);
        end
        req_wait_done(1, 20);
        vectors++;
        if (bus.readData1 !== 16'h2F00 || bus.readData0 !== 16'h0ABC) begin
            miscompares++;
            $display("FAIL p1_write_result: rdata1=%h rdata0=%h, required 2f00/0abc", bus.readData1, bus.readData0);
        end
    endtask

    task automatic test_same_cycle_ready();
        drdy_delay = 0;
        push_txn(1, 1'b0, 7'h41, 16'h0000, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        req_start(1, 1'b0, 7'h41, 16'h0000);
        req_wait_done(1, 20);
        vectors++;
        if (done_cyc[1] - den_cyc[1] != 1) begin
            miscompares++;
            $display("FAIL ready_in_den_cycle: den->done %0d cycles, required 1", done_cyc[1] - den_cyc[1]);
        end
    endtask

    task automatic test_simultaneous();
        drdy_delay = 1;
        push_txn(0, 1'b0, 7'h10, 16'h0000, 1'b0, 1'b1);
        push_txn(1, 1'b0, 7'h42, 16'h0000, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        req_start(0, 1'b0, 7'h10, 16'h0000);
        req_start(1, 1'b0, 7'h42, 16'h0000);
        fork
            begin req_wait_done(0, 30); end
            begin req_wait_done(1, 30); end
        join
        vectors++;
        if (den_cyc[1] - done_cyc[0] != 2 || done_cyc[0] >= done_cyc[1]) begin
            miscompares++;
            $display("FAIL simultaneous_order: done0@%0d den1@%0d done1@%0d, required den1 = done0+2 and done0 first",
                     done_cyc[0], den_cyc[1], done_cyc[1]);
        end
    endtask

    task automatic test_burst();
        drdy_delay = 1;
        for (int i = 0; i < 4; i++) push_txn(0, 1'b0, 7'(32'h20 + i), 16'h0000, 1'b0, 1'b1);
        push_txn(1, 1'b0, 7'h50, 16'h0000, 1'b0, 1'b1);
        for (int i = 4; i < 6; i++) push_txn(0, 1'b0, 7'(32'h20 + i), 16'h0000, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    req_start(0, 1'b0, 7'(32'h20 + i), 16'h0000);
                    req_wait_done(0, 40);
                end
            end
            begin
                req_start(1, 1'b0, 7'h50, 16'h0000);
                req_wait_done(1, 80);
            end
        join
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dones = 0;
        drdy_delay = 4;
        push_txn(0, 1'b0, 7'h15, 16'h0000, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        req_start(0, 1'b0, 7'h15, 16'h0000);
        wait_den(10, seen);
        @(posedge clock);
        #1;
        resetN       = 1'b0;
        bus.request0 = 1'b0;
        @(negedge clock);
        vectors++;
        if ({bus.done0, bus.done1, bus.DRPEnable, busy} !== 4'b0 || bus.readData0 !== '0 || bus.DRPAddress !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: flags=%b rdata0=%h addr=%h, required 0000/0000/00",
                     {bus.done0, bus.done1, bus.DRPEnable, busy}, bus.readData0, bus.DRPAddress);
        end
        @(posedge clock);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_late_drdy: %0d done pulses busy=%b, required 0 and 0", dones, busy);
        end
        drdy_delay = 2;
        push_txn(0, 1'b0, 7'h16, 16'h0000, 1'b0, 1'b1);
        req_start(0, 1'b0, 7'h16, 16'h0000);
        req_wait_done(0, 20);
    endtask

`ifdef DRP_TIMEOUT_EN
    task automatic test_timeout();
        xadc_mute = 1'b1;
        push_txn(0, 1'b0, 7'h17, 16'h0000, 1'b1, 1'b1);
        @(posedge clock);
        #1;
        req_start(0, 1'b0, 7'h17, 16'h0000);
        req_wait_done(0, 30);
        vectors++;
        if (done_cyc[0] - den_cyc[0] != TO || busy !== 1'b0 || bus.readData0 !== '0 || bus.error0 !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout: den->done %0d busy=%b rdata0=%h error0_after=%b, required %0d/0/0000/0",
                     done_cyc[0] - den_cyc[0], busy, bus.readData0, bus.error0, TO);
        end
        xadc_mute = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.request0     = 1'b0;
        bus.request1     = 1'b0;
        bus.writeEnable0 = 1'b0;
        bus.writeEnable1 = 1'b0;
        bus.address0     = '0;
        bus.address1     = '0;
        bus.writeData0   = '0;
        bus.writeData1   = '0;
        den_cyc          = '{0, 0};
        done_cyc         = '{0, 0};
        for (int a = 0; a < 128; a++) begin
            xadc_mem[a] = init_val(a);
            exp_mem[a]  = init_val(a);
        end

        test_reset();
        test_port0_read();
        test_port1_write();
        test_same_cycle_ready();
        test_simultaneous();
        test_burst();
        test_reset_mid();
`ifdef DRP_TIMEOUT_EN
        test_timeout();
`endif
        repeat (4) @(negedge clock);
        vectors++;
        if (den_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d DEN and %0d done still expected, required 0/0", den_q.size(), done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
